// File: rtl/ama_riscv_trace_sink.sv
// ama_riscv_trace_sink: first-word-fall-through buffer for the core retirement trace, with drop
// accounting, tohost end-of-test detection and optional statistics (macro TRACE_SINK_STATS_EN).
module ama_riscv_trace_sink #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ret_valid,
    input  logic [31:0]      ret_inst,
    input  logic [31:0]      ret_pc,
    input  logic             ret_branch_inst,
    input  logic             ret_branch_taken,
    input  logic             ret_bp_hit,
    input  logic [31:0]      ret_dmem_addr,
    input  logic [3:0]       ret_dmem_size,
    input  logic [31:0]      csr_tohost,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [102:0]     out_data,
    output logic             overflow,
    output logic [15:0]      dropped_cnt,
    output logic             done,
    output logic [31:0]      tohost_val,
    output logic [CNT_W-1:0] cnt_ret,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_bp_hit,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 103;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      dropped_cnt_q, dropped_cnt_d;
    logic [31:0]      tohost_val_q, tohost_val_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic             push;
    logic             drop;
    logic [REC_W-1:0] rec;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = !empty && out_ready;
    // The tohost capture cycle is still RUN, so its record is accepted like any other.
    assign accept = ret_valid && (state_q == RUN);
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;
    assign rec    = {ret_pc, ret_inst, ret_dmem_addr, ret_dmem_size,
                     ret_branch_inst, ret_branch_taken, ret_bp_hit};

    always_comb begin
        state_d       = state_q;
        tohost_val_d  = tohost_val_q;
        overflow_d    = overflow_q;
        dropped_cnt_d = dropped_cnt_q;
        wptr_d        = push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d        = pop ? (rptr_q + PTR_ONE) : rptr_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_cnt_q != 16'hFFFF) begin
                dropped_cnt_d = dropped_cnt_q + 16'd1;
            end
        end
        case (state_q)
            RUN: begin
                if (csr_tohost != 32'd0) begin
                    state_d      = DRAIN;
                    tohost_val_d = csr_tohost;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wptr_q        <= '0;
            rptr_q        <= '0;
            overflow_q    <= 1'b0;
            dropped_cnt_q <= 16'd0;
            tohost_val_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            overflow_q    <= overflow_d;
            dropped_cnt_q <= dropped_cnt_d;
            tohost_val_q  <= tohost_val_d;
        end
    end

    // Entry storage carries no reset; the empty mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= rec;
        end
    end

    assign out_valid   = !empty;
    assign out_data    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overflow    = overflow_q;
    assign dropped_cnt = dropped_cnt_q;
    assign done        = (state_q == DONE);
    assign tohost_val  = tohost_val_q;

`ifdef TRACE_SINK_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_ret_q, cnt_ret_d;
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
    logic [CNT_W-1:0] cnt_bp_hit_q, cnt_bp_hit_d;
    logic [CNT_W-1:0] cnt_load_q, cnt_load_d;
    logic [CNT_W-1:0] cnt_store_q, cnt_store_d;

    // Dropped records are still counted: the statistics describe retirement, not buffering.
    always_comb begin
        cnt_ret_d    = cnt_ret_q;
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        cnt_bp_hit_d = cnt_bp_hit_q;
        cnt_load_d   = cnt_load_q;
        cnt_store_d  = cnt_store_q;
        if (accept) begin
            cnt_ret_d = cnt_ret_q + CNT_ONE;
            if (ret_branch_inst) begin
                cnt_branch_d = cnt_branch_q + CNT_ONE;
                if (ret_branch_taken) cnt_taken_d = cnt_taken_q + CNT_ONE;
                if (ret_bp_hit) cnt_bp_hit_d = cnt_bp_hit_q + CNT_ONE;
            end
            if (ret_dmem_size < 4'd4) begin
                cnt_load_d = cnt_load_q + CNT_ONE;
            end else if (ret_dmem_size[3:2] == 2'b01) begin
                cnt_store_d = cnt_store_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ret_q    <= '0;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
            cnt_bp_hit_q <= '0;
            cnt_load_q   <= '0;
            cnt_store_q  <= '0;
        end else begin
            cnt_ret_q    <= cnt_ret_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
            cnt_bp_hit_q <= cnt_bp_hit_d;
            cnt_load_q   <= cnt_load_d;
            cnt_store_q  <= cnt_store_d;
        end
    end

    assign cnt_ret    = cnt_ret_q;
    assign cnt_branch = cnt_branch_q;
    assign cnt_taken  = cnt_taken_q;
    assign cnt_bp_hit = cnt_bp_hit_q;
    assign cnt_load   = cnt_load_q;
    assign cnt_store  = cnt_store_q;
`else
    assign cnt_ret    = '0;
    assign cnt_branch = '0;
    assign cnt_taken  = '0;
    assign cnt_bp_hit = '0;
    assign cnt_load   = '0;
    assign cnt_store  = '0;
`endif

endmodule
